// File: rtl/smr_pkg.sv
// Shared encodings for the SMR instruction controller: opcodes, states, mux codes.
package smr_pkg;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RM    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RN    = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    // Only the six supported MOV/ALU encodings are legal.
    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) ||
               ((opc == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));
    endfunction

endpackage

// File: rtl/smr_ctrl_decode.sv
// Moore output decode: current state plus latched instruction fields -> datapath controls.
module smr_ctrl_decode
    import smr_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  state_t     state,
    input  logic [2:0] opc,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] ALUop,
    output logic       illegal
);

    // Everything defaults low; each state raises only its own controls.
    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_C;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        ALUop   = ALUOP_ADD;
        illegal = 1'b0;
        case (state)
            S_WAIT:      w = 1'b1;
            S_DECODE:    illegal = !ILLEGAL_TRAP && !is_legal(opc, op);
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                loadc = 1'b1;
                // MOV reg passes B through as 0 + B
                if (opc == OPC_ALU) begin
                    ALUop = op;
                    loads = (op == OP_CMP);
                end else begin
                    asel  = 1'b1;
                end
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_ERR:       illegal = 1'b1;
            default:     w = 1'b1;
        endcase
    end

endmodule

// File: rtl/smr_ctrl_fsm.sv
// Multi-cycle instruction sequencer: state register, instruction latch, next-state logic.
module smr_ctrl_fsm
    import smr_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] ALUop,
    output logic       illegal
);

    state_t     state, state_nxt;
    logic [2:0] opc_q;
    logic [1:0] op_q;

    // State register; reset lands in WAIT even mid-instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_WAIT;
        else          state <= state_nxt;
    end

    // Instruction fields are captured only on acceptance so later input churn is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opc_q <= '0;
            op_q  <= '0;
        end else if ((state == S_WAIT) && s) begin
            opc_q <= opcode;
            op_q  <= op;
        end
    end

    // Next-state: dispatch from DECODE by instruction class, then fixed one-cycle steps.
    always_comb begin
        state_nxt = S_WAIT;
        case (state)
            S_WAIT:      state_nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (!is_legal(opc_q, op_q))
                    state_nxt = ILLEGAL_TRAP ? S_ERR : S_WAIT;
                else if (opc_q == OPC_MOV)
                    state_nxt = (op_q == OP_MOV_IMM) ? S_WRITE_IMM : S_GET_B;
                else
                    state_nxt = (op_q == OP_MVN) ? S_GET_B : S_GET_A;
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_ALU;
            S_ALU:       state_nxt = ((opc_q == OPC_ALU) && (op_q == OP_CMP)) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nxt = S_WAIT;
            S_ERR:       state_nxt = S_ERR;
            default:     state_nxt = S_WAIT;
        endcase
    end

    smr_ctrl_decode #(.ILLEGAL_TRAP(ILLEGAL_TRAP)) u_decode (
        .state   (state),
        .opc     (opc_q),
        .op      (op_q),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .ALUop   (ALUop),
        .illegal (illegal)
    );

endmodule
